// File: rtl/llc_pkg.sv
// Shared LLC coherence types and the MESI next-state rule applied by the bus sequencer.
package llc_pkg;

  typedef enum logic [1:0] {M, E, S, I} mesi_t;
  typedef enum logic [2:0] {NOP, READ, RWIM, INVALIDATE, WRITEBACK} bus_op_t;
  typedef enum logic [1:0] {NOHIT, HIT, HITM} snoop_t;

  localparam logic CMD_PRRD = 1'b0;
  localparam logic CMD_PRWR = 1'b1;

  // A tag match on an Invalid line carries no data, so it behaves as a miss.
  function automatic logic line_valid(input logic tag_hit, input mesi_t st);
    return tag_hit && (st != I);
  endfunction

  function automatic mesi_t mesi_next(input logic is_wr, input logic hit,
                                      input mesi_t cur, input snoop_t snoop);
    mesi_t nxt;
    if (is_wr)               nxt = M;
    else if (hit)            nxt = cur;
    else if (snoop == NOHIT) nxt = E;
    else                     nxt = S;
    return nxt;
  endfunction

endpackage

// File: rtl/llc_bus_sequencer.sv
// Sequences one CPU request at a time through optional victim writeback, a bus
// command, and the final MESI state write to the directory.
module llc_bus_sequencer
  import llc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 16   // must be >= 2: the ISSUE cycle never completes
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              tag_hit,
  input  mesi_t             line_state,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              bus_valid,
  output bus_op_t           bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  snoop_t            snoop_res,
  output logic              st_we,
  output mesi_t             st_val,
  output logic              done,
  output logic              err
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, WB, ISSUE, WAIT, UPD} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_tag_hit;
  mesi_t               r_line_state;
  logic                r_victim_dirty;
  logic [ADDR_W-1:0]   r_victim_addr;
  mesi_t               r_st_val;

  logic    w_accept;
  logic    w_line_hit;
  logic    w_fast_hit;
  logic    w_r_hit;
  logic    w_bus_active;
  logic    w_ack_seen;
  logic    w_expire;
  logic    w_load_cnt;
  bus_op_t w_issue_op;

  assign req_ready    = (r_state == IDLE);
  assign w_accept     = req_valid && req_ready;
  assign w_line_hit   = line_valid(tag_hit, line_state);
  assign w_fast_hit   = w_line_hit &&
                        ((req_cmd == CMD_PRRD) || (line_state == M) || (line_state == E));
  assign w_r_hit      = line_valid(r_tag_hit, r_line_state);
  assign w_bus_active = (r_state == WB) || (r_state == ISSUE) || (r_state == WAIT);
  assign w_ack_seen   = bus_ack && ((r_state == WB) || (r_state == WAIT));
  // A late ack in the final counted cycle still wins over the timeout.
  assign w_expire     = ((r_state == WB) || (r_state == WAIT)) && (r_cnt == '0) && !bus_ack;
  assign w_load_cnt   = (w_next_state != r_state) &&
                        ((w_next_state == WB) || (w_next_state == ISSUE));
  assign w_issue_op   = w_r_hit ? INVALIDATE : ((r_cmd == CMD_PRWR) ? RWIM : READ);

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together from the same pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the default at the top of each always_comb guarantees every output is
  // written on every path, so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fast_hit)        w_next_state = UPD;
          else if (w_line_hit)   w_next_state = ISSUE;
          else if (victim_dirty) w_next_state = WB;
          else                   w_next_state = ISSUE;
        end
      end
      WB: begin
        if (w_ack_seen)        w_next_state = ISSUE;
        else if (w_expire)     w_next_state = IDLE;
      end
      ISSUE:                   w_next_state = WAIT;
      WAIT: begin
        if (w_ack_seen)        w_next_state = UPD;
        else if (w_expire)     w_next_state = IDLE;
      end
      UPD:                     w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_cnt <= '0;
    else if (w_load_cnt)                   r_cnt <= CNT_LOAD;
    else if (w_bus_active && r_cnt != '0)  r_cnt <= r_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd          <= CMD_PRRD;
      r_addr         <= '0;
      r_tag_hit      <= 1'b0;
      r_line_state   <= I;
      r_victim_dirty <= 1'b0;
      r_victim_addr  <= '0;
    end else if (w_accept) begin
      r_cmd          <= req_cmd;
      r_addr         <= req_addr;
      r_tag_hit      <= tag_hit;
      r_line_state   <= line_state;
      r_victim_dirty <= victim_dirty;
      r_victim_addr  <= victim_addr;
    end
  end

  // Hits resolve at accept; bus paths resolve on the ack that ends WAIT, which is
  // the only place snoop_res is looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_st_val <= I;
    else if (w_accept && w_fast_hit)
      r_st_val <= mesi_next(req_cmd, 1'b1, line_state, NOHIT);
    else if ((r_state == WAIT) && bus_ack)
      r_st_val <= mesi_next(r_cmd, w_r_hit, r_line_state, snoop_res);
  end

  always_comb begin
    bus_valid = 1'b0;
    bus_op    = NOP;
    bus_addr  = '0;
    case (r_state)
      WB: begin
        bus_valid = 1'b1;
        bus_op    = WRITEBACK;
        bus_addr  = r_victim_addr;
      end
      ISSUE, WAIT: begin
        bus_valid = 1'b1;
        bus_op    = w_issue_op;
        bus_addr  = r_addr;
      end
      default: ;
    endcase
  end

  assign st_we  = (r_state == UPD);
  assign done   = (r_state == UPD);
  assign st_val = r_st_val;
  assign err    = w_expire;

  a_wb_needs_dirty: assert property (@(posedge clk) disable iff (!rst)
                                     (r_state == WB) |-> r_victim_dirty);
  a_we_err_exclusive: assert property (@(posedge clk) disable iff (!rst)
                                       !(st_we && err));

endmodule

// File: tb/tb_llc_bus_sequencer.sv
// Randomized and directed bench for llc_bus_sequencer against a transaction-level reference model.
module tb_llc_bus_sequencer;
  import llc_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int ACK_TIMEOUT = 16;
  localparam int BUDGET      = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_cmd;
  logic [ADDR_W-1:0] req_addr, victim_addr, bus_addr;
  logic              tag_hit, victim_dirty, bus_valid, bus_ack, st_we, done, err;
  mesi_t             line_state, st_val;
  bus_op_t           bus_op;
  snoop_t            snoop_res;

  always #5 clk = ~clk;

  llc_bus_sequencer #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .tag_hit(tag_hit), .line_state(line_state),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .snoop_res(snoop_res),
    .st_we(st_we), .st_val(st_val), .done(done), .err(err)
  );

  typedef struct {
    bus_op_t           op;
    logic [ADDR_W-1:0] addr;
    int                hold;
  } bus_rec_t;

  typedef struct {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic              hit;
    mesi_t             lstate;
    logic              vdirty;
    logic [ADDR_W-1:0] vaddr;
    snoop_t            snoop;
    int                d_wb;    // bus cycles until ack for WRITEBACK, 0 = never
    int                d_main;  // bus cycles until ack for the main op, 0 = never
  } txn_t;

  int       n_total = 0;
  int       n_pass  = 0;
  bus_rec_t obs_q[$];
  bus_rec_t exp_q[$];
  int       obs_we, obs_done, obs_err, obs_end_cyc;
  mesi_t    obs_st_val;
  bit       obs_unstable, obs_both, obs_hung;
  logic     obs_ready_acc, obs_ready_after, obs_valid_after, obs_pulse_after;
  bit       exp_err;
  mesi_t    exp_final;
  int       exp_end_cyc;
  bit       spurious = 1'b0;

  function automatic mesi_t rand_mesi();
    logic [1:0] v;
    v = 2'($urandom_range(0, 3));
    return mesi_t'(v);
  endfunction

  function automatic snoop_t rand_snoop();
    logic [1:0] v;
    v = 2'($urandom_range(0, 2));
    return snoop_t'(v);
  endfunction

  // Reference model: which bus ops a request needs, how long each is held,
  // whether it times out, and the MESI state it finally writes.
  task automatic model_txn(input txn_t t);
    bus_rec_t r;
    bit       eff_hit;
    int       sum;
    exp_q.delete();
    exp_err = 1'b0;
    exp_final = I;
    eff_hit = t.hit && (t.lstate != I);
    if (eff_hit && (!t.cmd || t.lstate == M || t.lstate == E)) begin
      exp_final = t.cmd ? M : t.lstate;
    end else if (eff_hit) begin
      r.op = INVALIDATE; r.addr = t.addr; r.hold = (t.d_main == 0) ? ACK_TIMEOUT : t.d_main;
      exp_q.push_back(r);
      exp_err = (t.d_main == 0);
      exp_final = M;
    end else begin
      if (t.vdirty) begin
        r.op = WRITEBACK; r.addr = t.vaddr; r.hold = (t.d_wb == 0) ? ACK_TIMEOUT : t.d_wb;
        exp_q.push_back(r);
        exp_err = (t.d_wb == 0);
      end
      if (!exp_err) begin
        r.op = t.cmd ? RWIM : READ; r.addr = t.addr;
        r.hold = (t.d_main == 0) ? ACK_TIMEOUT : t.d_main;
        exp_q.push_back(r);
        exp_err = (t.d_main == 0);
        exp_final = t.cmd ? M : ((t.snoop == NOHIT) ? E : S);
      end
    end
    sum = 0;
    foreach (exp_q[k]) sum += exp_q[k].hold;
    exp_end_cyc = exp_err ? sum : sum + 1;
  endtask

  // Issues one request, then plays a bus agent that acks after the requested
  // number of bus_valid cycles, recording everything the DUT does.
  task automatic run_txn(input txn_t t);
    int       run_len;
    int       cyc;
    int       d;
    bit       fin;
    bus_op_t  prev_op;
    bus_rec_t r;
    obs_q.delete();
    obs_we = 0; obs_done = 0; obs_err = 0; obs_end_cyc = -1; obs_st_val = I;
    obs_unstable = 0; obs_both = 0; obs_hung = 0;
    run_len = 0; cyc = 0; fin = 0; prev_op = NOP;
    @(negedge clk);
    bus_ack = 1'b0;
    req_valid = 1'b1; req_cmd = t.cmd; req_addr = t.addr; tag_hit = t.hit;
    line_state = t.lstate; victim_dirty = t.vdirty; victim_addr = t.vaddr;
    #1 obs_ready_acc = req_ready;
    @(negedge clk);
    req_valid = 1'b0; req_cmd = 1'($urandom_range(0, 1)); req_addr = $urandom;
    tag_hit = 1'($urandom_range(0, 1)); line_state = rand_mesi();
    victim_dirty = 1'($urandom_range(0, 1)); victim_addr = $urandom;
    while (!fin && cyc < BUDGET) begin
      cyc++;
      if (bus_valid) begin
        if (run_len == 0 || bus_op != prev_op) begin
          run_len = 1;
          r.op = bus_op; r.addr = bus_addr; r.hold = 0;
          obs_q.push_back(r);
        end else begin
          run_len++;
        end
        prev_op = bus_op;
      end else begin
        run_len = 0;
      end
      d = (bus_op == WRITEBACK) ? t.d_wb : t.d_main;
      if (bus_valid) bus_ack = (run_len == d);
      else           bus_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      snoop_res = bus_ack ? t.snoop : rand_snoop();
      #1;
      if (bus_valid && obs_q.size() > 0) begin
        obs_q[obs_q.size()-1].hold += 1;
        if (bus_addr !== obs_q[obs_q.size()-1].addr || bus_op !== obs_q[obs_q.size()-1].op)
          obs_unstable = 1;
      end
      if (st_we) begin obs_we++; obs_st_val = st_val; end
      if (done) obs_done++;
      if (err)  obs_err++;
      if (st_we && err) obs_both = 1;
      if (done || err) begin fin = 1; obs_end_cyc = cyc; end
      @(negedge clk);
    end
    obs_hung = !fin;
    bus_ack = 1'b0;
    #1;
    obs_ready_after = req_ready;
    obs_valid_after = bus_valid;
    obs_pulse_after = st_we | done | err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (bus_valid !== 1'b0) $display("FAIL reset.bus_valid: got %b expected 0", bus_valid); else n_pass++;
    n_total++; if (bus_op !== NOP) $display("FAIL reset.bus_op: got %0d expected %0d", bus_op, NOP); else n_pass++;
    n_total++; if (st_we !== 1'b0) $display("FAIL reset.st_we: got %b expected 0", st_we); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset.done: got %b expected 0", done); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset.err: got %b expected 0", err); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset.req_ready: got %b expected 1", req_ready); else n_pass++;
  endtask

  task automatic test_read_hit();
    txn_t t;
    t = '{cmd: 1'b0, addr: 32'h0000_1230, hit: 1'b1, lstate: E, vdirty: 1'b1,
          vaddr: 32'h0000_0080, snoop: HITM, d_wb: 2, d_main: 2};
    run_txn(t);
    n_total++; if (obs_ready_acc !== 1'b1) $display("FAIL read_hit.ready: got %b expected 1", obs_ready_acc); else n_pass++;
    n_total++; if (obs_q.size() != 0) $display("FAIL read_hit.bus_ops: got %0d expected 0", obs_q.size()); else n_pass++;
    n_total++; if (obs_end_cyc != 1) $display("FAIL read_hit.latency: got %0d expected 1", obs_end_cyc); else n_pass++;
    n_total++; if (obs_we != 1 || obs_st_val !== E) $display("FAIL read_hit.st_val: got we=%0d val=%0d expected we=1 val=%0d", obs_we, obs_st_val, E); else n_pass++;
  endtask

  task automatic test_write_shared();
    txn_t t;
    t = '{cmd: 1'b1, addr: 32'h0000_5540, hit: 1'b1, lstate: S, vdirty: 1'b0,
          vaddr: 32'h0, snoop: NOHIT, d_wb: 2, d_main: 3};
    run_txn(t);
    n_total++;
    if (obs_q.size() != 1 || obs_q[0].op !== INVALIDATE || obs_q[0].addr !== 32'h0000_5540 || obs_q[0].hold != 3)
      $display("FAIL write_shared.bus: got n=%0d op=%0d hold=%0d expected n=1 op=%0d hold=3",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].op : NOP, (obs_q.size() > 0) ? obs_q[0].hold : 0, INVALIDATE);
    else n_pass++;
    n_total++; if (obs_we != 1 || obs_st_val !== M) $display("FAIL write_shared.st_val: got we=%0d val=%0d expected we=1 val=%0d", obs_we, obs_st_val, M); else n_pass++;
    n_total++; if (obs_unstable) $display("FAIL write_shared.stable: got unstable=1 expected 0"); else n_pass++;
  endtask

  task automatic test_dirty_read_miss();
    txn_t t;
    t = '{cmd: 1'b0, addr: 32'h0000_9000, hit: 1'b0, lstate: M, vdirty: 1'b1,
          vaddr: 32'h0000_0040, snoop: HIT, d_wb: 2, d_main: 4};
    run_txn(t);
    n_total++; if (obs_q.size() != 2) $display("FAIL dirty_miss.n_ops: got %0d expected 2", obs_q.size()); else n_pass++;
    if (obs_q.size() == 2) begin
      n_total++; if (obs_q[0].op !== WRITEBACK || obs_q[0].addr !== 32'h40) $display("FAIL dirty_miss.wb: got op=%0d addr=%h expected op=%0d addr=40", obs_q[0].op, obs_q[0].addr, WRITEBACK); else n_pass++;
      n_total++; if (obs_q[1].op !== READ || obs_q[1].addr !== 32'h9000) $display("FAIL dirty_miss.read: got op=%0d addr=%h expected op=%0d addr=9000", obs_q[1].op, obs_q[1].addr, READ); else n_pass++;
    end
    n_total++; if (obs_st_val !== S || obs_end_cyc != 7) $display("FAIL dirty_miss.st_val: got val=%0d cyc=%0d expected val=%0d cyc=7", obs_st_val, obs_end_cyc, S); else n_pass++;
  endtask

  task automatic test_write_miss();
    txn_t t;
    t = '{cmd: 1'b1, addr: 32'h0000_a100, hit: 1'b0, lstate: I, vdirty: 1'b0,
          vaddr: 32'h0000_0777, snoop: HITM, d_wb: 2, d_main: 2};
    run_txn(t);
    n_total++; if (obs_q.size() != 1 || obs_q[0].op !== RWIM) $display("FAIL write_miss.op: got n=%0d expected one RWIM", obs_q.size()); else n_pass++;
    n_total++; if (obs_st_val !== M) $display("FAIL write_miss.st_val: got %0d expected %0d", obs_st_val, M); else n_pass++;
    n_total++; if (obs_done != 1 || obs_pulse_after !== 1'b0) $display("FAIL write_miss.done_pulse: got count=%0d after=%b expected 1/0", obs_done, obs_pulse_after); else n_pass++;
  endtask

  task automatic test_timeout();
    txn_t t;
    t = '{cmd: 1'b0, addr: 32'h0000_b000, hit: 1'b0, lstate: S, vdirty: 1'b0,
          vaddr: 32'h0, snoop: NOHIT, d_wb: 2, d_main: 0};
    run_txn(t);
    n_total++; if (obs_hung) $display("FAIL timeout.hung: got no completion expected err"); else n_pass++;
    n_total++; if (obs_err != 1 || obs_we != 0) $display("FAIL timeout.err: got err=%0d we=%0d expected 1/0", obs_err, obs_we); else n_pass++;
    n_total++; if (obs_q.size() != 1 || obs_q[0].hold != ACK_TIMEOUT) $display("FAIL timeout.hold: got %0d expected %0d", (obs_q.size() > 0) ? obs_q[0].hold : 0, ACK_TIMEOUT); else n_pass++;
    n_total++; if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0) $display("FAIL timeout.after: got ready=%b valid=%b expected 1/0", obs_ready_after, obs_valid_after); else n_pass++;
    // ack in the very last allowed cycle must complete, not error
    t.d_main = ACK_TIMEOUT;
    run_txn(t);
    n_total++; if (obs_err != 0 || obs_we != 1 || obs_st_val !== E) $display("FAIL timeout.edge_ack: got err=%0d we=%0d val=%0d expected 0/1/%0d", obs_err, obs_we, obs_st_val, E); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 1'b0; req_addr = 32'h0000_c000; tag_hit = 1'b0;
    line_state = I; victim_dirty = 1'b0; victim_addr = '0; bus_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (bus_valid !== 1'b1) $display("FAIL reset_wait.pre_valid: got %b expected 1", bus_valid); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bus_valid !== 1'b0 || bus_op !== NOP) $display("FAIL reset_wait.valid: got valid=%b op=%0d expected 0/%0d", bus_valid, bus_op, NOP); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus_ack = 1'($urandom_range(0, 1));
      snoop_res = rand_snoop();
      #1;
      if (st_we || done || err || bus_valid) bad++;
    end
    bus_ack = 1'b0;
    n_total++; if (bad != 0) $display("FAIL reset_wait.quiet: got %0d active cycles expected 0", bad); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_wait.ready: got %b expected 1", req_ready); else n_pass++;
  endtask

  task automatic test_random(input int n);
    txn_t t;
    for (int k = 0; k < n; k++) begin
      t.cmd = 1'($urandom_range(0, 1));
      t.addr = $urandom;
      t.hit = 1'($urandom_range(0, 1));
      t.lstate = rand_mesi();
      t.vdirty = 1'($urandom_range(0, 1));
      t.vaddr = $urandom;
      t.snoop = rand_snoop();
      t.d_wb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      t.d_main = ($urandom_range(0, 9) == 0) ? 0 :
                 (($urandom_range(0, 7) == 0) ? ACK_TIMEOUT : int'($urandom_range(2, 6)));
      spurious = 1'($urandom_range(0, 1));
      model_txn(t);
      run_txn(t);
      n_total++;
      if (obs_q.size() != exp_q.size())
        $display("FAIL random[%0d].n_ops: got %0d expected %0d", k, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
        n_total++;
        if (obs_q[j].op !== exp_q[j].op || obs_q[j].addr !== exp_q[j].addr || obs_q[j].hold != exp_q[j].hold)
          $display("FAIL random[%0d].op%0d: got op=%0d addr=%h hold=%0d expected op=%0d addr=%h hold=%0d",
                   k, j, obs_q[j].op, obs_q[j].addr, obs_q[j].hold, exp_q[j].op, exp_q[j].addr, exp_q[j].hold);
        else n_pass++;
      end
      n_total++;
      if (obs_err != int'(exp_err) || obs_we != int'(!exp_err) || obs_done != int'(!exp_err))
        $display("FAIL random[%0d].outcome: got err=%0d we=%0d done=%0d expected err=%0d", k, obs_err, obs_we, obs_done, exp_err);
      else n_pass++;
      if (!exp_err) begin
        n_total++;
        if (obs_st_val !== exp_final) $display("FAIL random[%0d].st_val: got %0d expected %0d", k, obs_st_val, exp_final);
        else n_pass++;
      end
      n_total++;
      if (obs_end_cyc != exp_end_cyc) $display("FAIL random[%0d].latency: got %0d expected %0d", k, obs_end_cyc, exp_end_cyc);
      else n_pass++;
      n_total++;
      if (obs_unstable || obs_both || obs_pulse_after !== 1'b0 || obs_ready_after !== 1'b1)
        $display("FAIL random[%0d].protocol: got unstable=%0d both=%0d pulse_after=%b ready=%b expected 0/0/0/1",
                 k, obs_unstable, obs_both, obs_pulse_after, obs_ready_after);
      else n_pass++;
    end
    spurious = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0; req_cmd = 1'b0; req_addr = '0; tag_hit = 1'b0; line_state = I;
    victim_dirty = 1'b0; victim_addr = '0; bus_ack = 1'b0; snoop_res = NOHIT;
    test_reset();
    test_read_hit();
    test_write_shared();
    test_dirty_read_miss();
    test_write_miss();
    test_timeout();
    test_reset_in_wait();
    test_read_hit();
    test_random(60);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
